// File: rtl/tick_counter_pkg.sv
// Shared types and elaboration helpers for the parametrised tick counter.
package tick_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // A zero TICK_HZ yields DIV=0 so the range check in tick_gen fires instead of a divide error.
  function automatic int div_of(input int clk_hz, input int tick_hz);
    return (tick_hz <= 0) ? 0 : clk_hz / tick_hz;
  endfunction

  function automatic int phase_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: free-running phase counter that raises a one-cycle tick enable every DIV cycles.
module tick_gen
  import tick_counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV = div_of(CLK_HZ, TICK_HZ);
  localparam int PW  = phase_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: CLK_HZ/TICK_HZ must be at least 1");
  end

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // With DIV==1 LAST is 0 and phase never moves, so tick simply follows en.
  assign tick_o = en_i & (phase_q == LAST);

endmodule

// File: rtl/tick_counter_param.sv
// Modulo-MOD up/down counter advanced by the prescaler tick, with load and saturating wrap count.
module tick_counter_param
  import tick_counter_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8,
  parameter int MOD     = 256,
  parameter int WRAP_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              up_dn_i,
  input  logic              load_en_i,
  input  logic [WIDTH-1:0]  load_val_i,
  output logic [WIDTH-1:0]  count_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              wrap_pulse_o,
  output logic              tc_o,
  output logic              tick_o
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("tick_counter_param: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0]  TOP      = WIDTH'(MOD - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic              tick;
  dir_e              dir;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WIDTH-1:0]  load_clamped;

  assign dir = dir_e'(up_dn_i);

  // Loading restarts the prescaler so the first tick after a load is a full period away.
  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .clr_i  (load_en_i),
    .tick_o (tick)
  );

  assign load_clamped = (load_val_i > TOP) ? TOP : load_val_i;

  always_comb begin
    count_d      = count_q;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_pulse_d = 1'b0;
    if (load_en_i) begin
      count_d    = load_clamped;
      wrap_cnt_d = '0;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (count_q == TOP) begin
          count_d      = '0;
          wrap_pulse_d = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d      = TOP;
          wrap_pulse_d = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      if (wrap_pulse_d && wrap_cnt_q != WRAP_MAX) begin
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      wrap_cnt_q   <= '0;
      wrap_pulse_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign count_o      = count_q;
  assign wrap_cnt_o   = wrap_cnt_q;
  assign wrap_pulse_o = wrap_pulse_q;
  assign tick_o       = tick;
  assign tc_o         = (dir == DIR_UP) ? (count_q == TOP) : (count_q == '0);

endmodule

// File: tb/tb_tick_counter_param.sv
// Self-checking bench for tick_counter_param: load table, directed corner sequences, random run.
module tb_tick_counter_param;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int WIDTH   = 4;
  localparam int MOD     = 10;
  localparam int WRAP_W  = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WMAX    = (1 << WRAP_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              en_i = 1'b0;
  logic              up_dn_i = 1'b0;
  logic              load_en_i = 1'b0;
  logic [WIDTH-1:0]  load_val_i = '0;
  logic [WIDTH-1:0]  count_o;
  logic [WRAP_W-1:0] wrap_cnt_o;
  logic              wrap_pulse_o;
  logic              tc_o;
  logic              tick_o;

  tick_counter_param #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .WIDTH   (WIDTH),
    .MOD     (MOD),
    .WRAP_W  (WRAP_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .up_dn_i      (up_dn_i),
    .load_en_i    (load_en_i),
    .load_val_i   (load_val_i),
    .count_o      (count_o),
    .wrap_cnt_o   (wrap_cnt_o),
    .wrap_pulse_o (wrap_pulse_o),
    .tc_o         (tc_o),
    .tick_o       (tick_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference state: prescaler phase, count value, wrap total, pulse seen after last edge.
  int m_phase = 0;
  int m_count = 0;
  int m_wrap  = 0;
  int m_pulse = 0;

  typedef struct {
    int lv;
    bit up;
    int exp_count;
    int exp_tc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic check_all(input string tag);
    int exp_tick;
    int exp_tc;
    exp_tick = (en_i && m_phase == DIV - 1) ? 1 : 0;
    exp_tc   = up_dn_i ? ((m_count == MOD - 1) ? 1 : 0) : ((m_count == 0) ? 1 : 0);
    check({tag, ".count"}, int'(count_o), m_count);
    check({tag, ".wrap_cnt"}, int'(wrap_cnt_o), m_wrap);
    check({tag, ".wrap_pulse"}, int'(wrap_pulse_o), m_pulse);
    check({tag, ".tick"}, int'(tick_o), exp_tick);
    check({tag, ".tc"}, int'(tc_o), exp_tc);
  endtask

  task automatic step(input string tag);
    bit t;
    int n_phase;
    int n_count;
    int n_wrap;
    int n_pulse;
    t       = en_i && (m_phase == DIV - 1);
    n_phase = m_phase;
    n_count = m_count;
    n_wrap  = m_wrap;
    n_pulse = 0;
    if (load_en_i) begin
      n_count = (int'(load_val_i) > MOD - 1) ? MOD - 1 : int'(load_val_i);
      n_wrap  = 0;
      n_phase = 0;
    end else begin
      if (en_i) n_phase = (m_phase + 1) % DIV;
      if (t) begin
        if (up_dn_i) begin
          n_pulse = (m_count == MOD - 1) ? 1 : 0;
          n_count = (m_count + 1) % MOD;
        end else begin
          n_pulse = (m_count == 0) ? 1 : 0;
          n_count = (m_count + MOD - 1) % MOD;
        end
        if (n_pulse == 1) n_wrap = (m_wrap < WMAX) ? m_wrap + 1 : WMAX;
      end
    end
    @(posedge clk_i);
    #1;
    m_phase = n_phase;
    m_count = n_count;
    m_wrap  = n_wrap;
    m_pulse = n_pulse;
    check_all(tag);
  endtask

  // Steps until a cycle with tick high has been clocked; n is the number of cycles used.
  task automatic run_to_tick(input string tag, input int max, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < max) begin
      hit = tick_o;
      step(tag);
      n++;
    end
    if (!hit) fail({tag, ".timeout"});
  endtask

  initial begin
    int ticks;
    int pulses;
    int n;

    vecs[0] = '{lv: 15, up: 1'b1, exp_count: 9, exp_tc: 1};
    vecs[1] = '{lv: 3,  up: 1'b1, exp_count: 3, exp_tc: 0};
    vecs[2] = '{lv: 0,  up: 1'b0, exp_count: 0, exp_tc: 1};
    vecs[3] = '{lv: 9,  up: 1'b0, exp_count: 9, exp_tc: 0};
    vecs[4] = '{lv: 10, up: 1'b1, exp_count: 9, exp_tc: 1};
    vecs[5] = '{lv: 0,  up: 1'b1, exp_count: 0, exp_tc: 0};
    vecs[6] = '{lv: 15, up: 1'b0, exp_count: 9, exp_tc: 0};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    rst_ni  = 1'b1;
    en_i    = 1'b1;
    up_dn_i = 1'b1;

    // 100 cycles counting up: ten ticks, one wrap
    ticks  = 0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (tick_o) ticks++;
      step("run_up");
      if (wrap_pulse_o) pulses++;
    end
    check("run_up.ticks", ticks, 10);
    check("run_up.pulses", pulses, 1);
    check("run_up.final_count", int'(count_o), 0);
    check("run_up.final_wrap", int'(wrap_cnt_o), 1);

    // Down from zero: tc immediately, then wrap to MOD-1
    up_dn_i = 1'b0;
    #1;
    check("down.tc_at_zero", int'(tc_o), 1);
    run_to_tick("down", 3 * DIV, n);
    check("down.cycles", n, DIV);
    check("down.count", int'(count_o), MOD - 1);
    check("down.pulse", int'(wrap_pulse_o), 1);

    // Load table with prescaler frozen
    en_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      up_dn_i    = vecs[i].up;
      load_val_i = WIDTH'(vecs[i].lv);
      load_en_i  = 1'b1;
      step("load");
      load_en_i  = 1'b0;
      #1;
      $display("load lv=%0d up=%0d -> count=%0d tc=%0d", vecs[i].lv, vecs[i].up, count_o, tc_o);
      check("tbl.count", int'(count_o), vecs[i].exp_count);
      check("tbl.tc", int'(tc_o), vecs[i].exp_tc);
      check("tbl.wrap_cnt", int'(wrap_cnt_o), 0);
    end

    // After clamped load to 9, first count change lands a full period later
    en_i = 1'b1;
    n    = 0;
    while (count_o == WIDTH'(MOD - 1) && n < 3 * DIV) begin
      step("post_load");
      n++;
    end
    check("post_load.cycles", n, DIV);
    check("post_load.count", int'(count_o), MOD - 2);

    // Load coinciding with tick wins; no increment, no wrap
    up_dn_i = 1'b1;
    n       = 0;
    while (!tick_o && n < 3 * DIV) begin
      step("coload.wait");
      n++;
    end
    if (!tick_o) fail("coload.timeout");
    load_val_i = 4'd3;
    load_en_i  = 1'b1;
    step("coload");
    load_en_i  = 1'b0;
    check("coload.count", int'(count_o), 3);
    check("coload.pulse", int'(wrap_pulse_o), 0);

    // Freeze at phase 4 for 20 cycles, then resume
    repeat (4) step("to_phase4");
    en_i  = 1'b0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (tick_o) ticks++;
      step("frozen");
    end
    check("frozen.ticks", ticks, 0);
    en_i = 1'b1;
    n    = 0;
    while (!tick_o && n < 3 * DIV) begin
      step("resume");
      n++;
    end
    check("resume.tick_cycle", n + 1, DIV - 4);

    // Four wraps saturate the wrap counter
    up_dn_i    = 1'b1;
    load_val_i = 4'd0;
    load_en_i  = 1'b1;
    step("sat.load");
    load_en_i  = 1'b0;
    repeat (45 * DIV) step("sat");
    check("sat.wrap_cnt", int'(wrap_cnt_o), WMAX);

    // Randomised traffic against the reference
    for (int i = 0; i < 600; i++) begin
      en_i       = ($urandom % 8) != 0;
      if ($urandom % 16 == 0) up_dn_i = ~up_dn_i;
      load_en_i  = ($urandom % 32) == 0;
      load_val_i = WIDTH'($urandom % 16);
      step("rand");
    end
    load_en_i = 1'b0;

    // Asynchronous reset in mid-cycle clears state before the next edge
    up_dn_i    = 1'b1;
    en_i       = 1'b1;
    load_val_i = 4'd5;
    load_en_i  = 1'b1;
    step("arst.load");
    load_en_i  = 1'b0;
    repeat (3) step("arst.run");
    #2;
    rst_ni  = 1'b0;
    #1;
    m_phase = 0;
    m_count = 0;
    m_wrap  = 0;
    m_pulse = 0;
    check_all("arst");
    @(posedge clk_i);
    #1;
    check_all("arst.hold");
    rst_ni = 1'b1;
    step("arst.release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
